imem_loader: RTL
================

# imem_loader

Program loader that fills the instruction memory from a byte stream before the core runs. It accepts bytes over a valid/ready handshake, packs them big-endian into 32-bit MIPS instruction words, and drives a single-cycle write port at word-aligned byte addresses (word index = address >> 2). While loading it holds the CPU in reset via `cpu_hold`, so instruction fetch never sees a partially written program.

## Interface
- `MAX_WORDS`, default 256: instruction memory depth in words; `word_count` is clamped to this value.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a load when in IDLE or DONE.
- `base_addr`  in  32  byte address of the first word; bits [1:0] ignored (forced 0); sampled on `start`.
- `word_count`  in  9  number of words to load (0..256); sampled on `start`.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  write strobe to instruction memory, one cycle per word.
- `mem_addr`  out  32  byte address of the word being written, always word-aligned.
- `mem_wdata`  out  32  packed instruction word.
- `busy`  out  1  load in progress.
- `done`  out  1  load complete; held until the next accepted `start` or reset.
- `err`  out  1  checksum mismatch, valid while `done` is high.
- `cpu_hold`  out  1  high whenever `busy` is high.

## Operation
- States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
- IDLE/DONE + `start`:
  - Latch base with [1:0]=0 and count = min(`word_count`, MAX_WORDS).
  - Clear the byte counter and `done`.
  - count=0: go to DONE next cycle (no writes, `err`=0). Otherwise go to RECV.
- RECV:
  - `in_ready`=1. A byte is accepted when `in_valid && in_ready`.
  - Bytes 0..3 land in [31:24], [23:16], [15:8], [7:0].
  - After the 4th byte, go to WRITE.
- WRITE: exactly one cycle.
  - `mem_we`=1; `mem_addr` = base + 4·index; `mem_wdata` = packed word.
  - Then increment index. If index = count, go to DONE (or CHECK with macro); else go to RECV.
- Address arithmetic is modulo 2^32; wrap-around is not an error.
- `start` while `busy` is ignored.
- `in_valid` outside RECV/CHECK is not consumed, and input bytes are never dropped.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=0.
- `busy` and `cpu_hold` rise the cycle after `start` and fall the same edge `done` rises.
- `mem_we` asserts the cycle after the 4th byte is accepted. `in_ready` is 0 in that cycle.
- Minimum cadence is 5 cycles per word with continuous `in_valid`.
- `mem_addr` and `mem_wdata` are registered and change only in the cycle of a WRITE.
- Reset mid-load aborts immediately: the partial word is discarded, already-written words stay in memory, and `cpu_hold` drops.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - Keep a 32-bit running sum (mod 2^32) of the written words.
  - After the last data word, CHECK receives 4 more bytes, packed the same way, with `in_ready`=1.
  - This checksum word is not written to memory.
  - Set `err`=1 if it differs from the sum, then go to DONE. `busy` remains high through CHECK.
- Not defined: no CHECK state, and `err` is tied to 0.

## Structure
- Package `imem_pkg`:
  - state enum type;
  - `IMEM_WORDS`=256;
  - `WORD_BYTES`=4;
  - `IMEM_ADDR_SHIFT`=2. The instruction memory uses the same constants for its read indexing.
- Sub-module `byte_packer`:
  - 2-bit byte counter plus 32-bit shift register;
  - `clear`, `push`, `byte_in` inputs;
  - `word`, `full` outputs.
  - Instantiated once, shared by RECV and CHECK.

## Test plan
- Reset, then `start`, base=0x0, count=2, bytes 20 08 00 05 00 00 00 0C, `in_valid` continuous:
  - writes 0x20080005 @0x0 and 0x0000000C @0x4;
  - 5 cycles apart;
  - then `done`=1 and `cpu_hold`=0.
- Base=0x00000013, count=1:
  - `mem_addr`=0x00000010.
- Count=0:
  - `done` the cycle after `start`;
  - no `mem_we` pulses.
- `in_valid` toggling every other cycle with count=3:
  - exactly 3 writes with correct packing;
  - no byte lost or duplicated;
  - extra `start` mid-load is ignored.
- Assert `rst_n` low after 2 words of 4:
  - all outputs return to reset values asynchronously;
  - a new load from base 0x40 then completes normally.
- With `IMEM_LOADER_CHECKSUM_EN`, words 0x1, 0x2:
  - checksum 0x3 gives `err`=0;
  - checksum 0x4 gives `err`=1;
  - the checksum word is never written.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction memory loader.
// The instruction memory uses the same word/shift constants for read indexing.
package imem_pkg;

  localparam int IMEM_WORDS      = 256;
  localparam int WORD_BYTES      = 4;
  localparam int IMEM_ADDR_SHIFT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words.
// Ports: clk, rst_n, clear, push, byte_in[7:0] -> word[31:0], full.
// word is the packed value including byte_in; full flags the push
// that completes a word, so the caller can register it that edge.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  logic [1:0]  cnt_q;
  logic [31:0] sh_q;

  assign word = {sh_q[23:0], byte_in};
  assign full = push && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      sh_q  <= '0;
    end else if (push) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a big-endian byte stream into instruction memory, holding the CPU.
// Ports: clk, rst_n, start, base_addr, word_count, in_valid/in_data/in_ready,
// mem_we/mem_addr/mem_wdata, busy, done, err, cpu_hold.
// Macro IMEM_LOADER_CHECKSUM_EN adds a trailing checksum word and err.
module imem_loader
  import imem_pkg::*;
#(
  parameter int MAX_WORDS = IMEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [8:0]  word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  state_e      state_q;
  logic [31:0] base_q;
  logic [8:0]  cnt_q;
  logic [8:0]  idx_q;
  logic        in_ready_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  logic [8:0]  count_d;
  logic        start_acc;
  logic        push;
  logic [31:0] pk_word;
  logic        pk_full;
  logic        last_word;
  logic        unused_base;

  assign unused_base = ^base_addr[1:0];

  assign count_d = ({23'b0, word_count} > 32'(MAX_WORDS))
                 ? 9'(MAX_WORDS) : word_count;

  assign start_acc = start &&
    (state_q == S_IDLE || state_q == S_DONE);
  assign push      = in_valid && in_ready_q;
  assign last_word = (idx_q + 9'd1) == cnt_q;

  byte_packer u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .push    (push),
    .byte_in (in_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q <= {base_addr[31:2], 2'b00};
            cnt_q  <= count_d;
            idx_q  <= '0;
            err_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q  <= '0;
`endif
            if (count_d == 9'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_RECV;
              done_q     <= 1'b0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (pk_full) begin
            state_q    <= S_WRITE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b1;
            addr_q     <= base_q +
              (32'(idx_q) << IMEM_ADDR_SHIFT);
            wdata_q    <= pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + pk_word;
`endif
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + 9'd1;
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= S_CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
`endif
          end else begin
            state_q    <= S_RECV;
            in_ready_q <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (pk_full) begin
            err_q      <= (pk_word != sum_q);
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end
        end
`endif
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cpu_hold  = busy_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
